// File: rtl/ppu_pipeline_pkg.sv
// Shared defaults and bundle-width helper for the PPU register-delay line.
package ppu_pipeline_pkg;

    localparam int PPU_PIPELINE_DEFAULT_DEPTH = 1;
    localparam int PPU_PIPELINE_DEFAULT_WIDTH = 32;

    // Front-side bundle: valid bit, opcode and three operand words.
    function automatic int ppu_front_width(input int op_bits, input int word_bits);
        return 1 + op_bits + 3 * word_bits;
    endfunction

endpackage

// File: rtl/ppu_pipeline_if.sv
// Bundle interface for the PPU register-delay line; the pipeline is the slave.
interface ppu_pipeline_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output data_in,
        input  data_out
    );

    modport slave (
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/ppu_pipeline_stage.sv
// One DATA_WIDTH register of the delay line with synchronous active-high clear.
module ppu_pipeline_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // Clear has priority over loading the incoming bundle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q <= {DATA_WIDTH{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ppu_pipeline.sv
// Parameterised register-delay line; depth 0 is a plain wire.
// Optional simulation checks are elaborated when PIPELINE_ASSERT_EN is defined.
module ppu_pipeline
    import ppu_pipeline_pkg::*;
#(
    parameter int PIPELINE_DEPTH = PPU_PIPELINE_DEFAULT_DEPTH,
    parameter int DATA_WIDTH     = PPU_PIPELINE_DEFAULT_WIDTH
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ppu_pipeline_if.slave  bus
);

    generate
        if (PIPELINE_DEPTH <= 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign bus.data_out   = bus.data_in;
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] stage_r [PIPELINE_DEPTH];
            for (genvar k = 0; k < PIPELINE_DEPTH; k++) begin : g_stage
                logic [DATA_WIDTH-1:0] stage_d_s;
                if (k == 0) begin : g_head
                    assign stage_d_s = bus.data_in;
                end else begin : g_link
                    assign stage_d_s = stage_r[k-1];
                end
                ppu_pipeline_stage #(
                    .DATA_WIDTH (DATA_WIDTH)
                ) u_stage (
                    .clk_i (clk_i),
                    .rst_i (rst_i),
                    .d     (stage_d_s),
                    .q     (stage_r[k])
                );
            end
            assign bus.data_out = stage_r[PIPELINE_DEPTH-1];
        end
    endgenerate

`ifdef PIPELINE_ASSERT_EN
    ppu_pipeline_chk #(
        .PIPELINE_DEPTH (PIPELINE_DEPTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_in (bus.data_in)
    );
`endif

endmodule

`ifdef PIPELINE_ASSERT_EN
// Simulation-only parameter and input-integrity checks for ppu_pipeline.
module ppu_pipeline_chk #(
    parameter int PIPELINE_DEPTH = 1,
    parameter int DATA_WIDTH     = 32
) (
    input logic                  clk_i,
    input logic                  rst_i,
    input logic [DATA_WIDTH-1:0] data_in
);

    // Parameter sanity and configuration report at time 0.
    initial begin
        if (PIPELINE_DEPTH < 0) begin
            $fatal(1, "ppu_pipeline: PIPELINE_DEPTH %0d is negative", PIPELINE_DEPTH);
        end
        if (DATA_WIDTH < 1) begin
            $fatal(1, "ppu_pipeline: DATA_WIDTH %0d is below 1", DATA_WIDTH);
        end
        $display("ppu_pipeline: depth %0d width %0d", PIPELINE_DEPTH, DATA_WIDTH);
    end

    // Unknown bits entering the line outside reset are almost always a wiring bug.
    always @(posedge clk_i) begin
        if (!rst_i && $isunknown(data_in)) begin
            $warning("ppu_pipeline: X/Z on data_in");
        end
    end

endmodule
`endif

// File: tb/tb_ppu_pipeline.sv
// Randomised and directed bench for ppu_pipeline at depths 0, 1, 3 and 2 (97-bit bundle).
module tb_ppu_pipeline;
    import ppu_pipeline_pkg::*;

    localparam int WIDE = ppu_front_width(0, 32);

    typedef logic [96:0] w_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    w_t vals[$];
    bit rsts[$];

    ppu_pipeline_if #(.DATA_WIDTH(8))    if0 ();
    ppu_pipeline_if #(.DATA_WIDTH(8))    if1 ();
    ppu_pipeline_if #(.DATA_WIDTH(16))   if3 ();
    ppu_pipeline_if #(.DATA_WIDTH(WIDE)) if2 ();

    ppu_pipeline #(.PIPELINE_DEPTH(0), .DATA_WIDTH(8))    dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    ppu_pipeline #(.PIPELINE_DEPTH(1), .DATA_WIDTH(8))    dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    ppu_pipeline #(.PIPELINE_DEPTH(3), .DATA_WIDTH(16))   dut3 (.clk_i(clk), .rst_i(rst), .bus(if3));
    ppu_pipeline #(.PIPELINE_DEPTH(2), .DATA_WIDTH(WIDE)) dut2 (.clk_i(clk), .rst_i(rst), .bus(if2));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int cyc, input w_t got, input w_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic w_t width_mask(input int w);
        w_t ones;
        ones = '1;
        return ones >> (97 - w);
    endfunction

    // Output after edge n: the value driven d-1 edges earlier, unless a reset
    // edge fell inside that window, in which case the line holds zeros.
    function automatic w_t model_out(input int d, input int n, input int w);
        if (d == 0) begin
            return vals[n] & width_mask(w);
        end
        for (int k = n - d + 1; k <= n; k++) begin
            if (k < 0 || rsts[k]) begin
                return '0;
            end
        end
        return vals[n - d + 1] & width_mask(w);
    endfunction

    task automatic push(input bit r, input w_t v);
        rsts.push_back(r);
        vals.push_back(v);
    endtask

    task automatic check_all(input int n);
        check_eq("depth0_w8",  n, w_t'(if0.data_out), model_out(0, n, 8));
        check_eq("depth1_w8",  n, w_t'(if1.data_out), model_out(1, n, 8));
        check_eq("depth3_w16", n, w_t'(if3.data_out), model_out(3, n, 16));
        check_eq("depth2_w97", n, w_t'(if2.data_out), model_out(2, n, WIDE));
    endtask

    initial begin
        w_t tmp;
        // Directed prefix: reset with live data, short streams, mid-flight reset, wide patterns.
        push(1'b1, 97'h0A5);
        push(1'b1, 97'h0A5);
        push(1'b0, 97'h03C);
        for (int i = 1; i <= 5; i++) push(1'b0, w_t'(i));
        push(1'b0, 97'd7);
        push(1'b0, 97'd8);
        push(1'b0, 97'd9);
        push(1'b1, 97'h0FF);
        for (int i = 10; i <= 14; i++) push(1'b0, w_t'(i));
        tmp = '1;
        push(1'b0, tmp);
        for (int i = 0; i < 97; i++) begin
            tmp = 97'd1 << i;
            push(1'b0, tmp);
        end
        for (int i = 0; i < 300; i++) begin
            tmp = {$urandom(), $urandom(), $urandom(), 1'($urandom())};
            push(($urandom() % 16) == 0, tmp);
        end

        for (int n = 0; n < vals.size(); n++) begin
            @(negedge clk);
            if (n > 0) check_all(n - 1);
            rst          = rsts[n];
            if0.data_in  = vals[n][7:0];
            if1.data_in  = vals[n][7:0];
            if3.data_in  = vals[n][15:0];
            if2.data_in  = vals[n][WIDE-1:0];
            #1;
            check_eq("depth0_comb", n, w_t'(if0.data_out), vals[n] & width_mask(8));
        end
        @(negedge clk);
        check_all(vals.size() - 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_pipeline.md
# ppu_pipeline

Parameterised register-delay line for the posit processing unit datapath. It delays an arbitrary-width bundle of signals by a compile-time number of clock cycles. Typical bundles are input valid, opcode and operands on the front side, and result, valid and fixed-point on the back side. Depth 0 degenerates to a wire, so the PPU wrapper can retime itself without structural changes.

## Interface
Parameters:
- PIPELINE_DEPTH, default 1: number of register stages; integer ≥ 0.
- DATA_WIDTH, default 32: width in bits of the bundle; integer ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk_i  input  1  sole clock; all stages update on its rising edge.
- rst_i  input  1  synchronous, active-high reset; clears every stage.
- data_in  input  DATA_WIDTH  bundle entering stage 0.
- data_out  output  DATA_WIDTH  bundle leaving the last stage.

## Operation
- Chain of PIPELINE_DEPTH registers, each DATA_WIDTH bits: stage[0] ← data_in, stage[k] ← stage[k-1], data_out = stage[PIPELINE_DEPTH-1].
- PIPELINE_DEPTH = 0: data_out = data_in combinationally; no flops; rst_i and clk_i unused.
- Bundle is opaque: no field interpretation, no bit reordering; MSB of data_in stays MSB of data_out.
- No stall, enable or flush input; every stage shifts every cycle.
- Reset: when rst_i = 1 at a rising edge, all stages load all-zeros (including any valid bit packed in the bundle); data_in is ignored that cycle.
- Reset has priority over shifting; no partial clearing.

## Timing
- Latency exactly PIPELINE_DEPTH cycles: a value on data_in before edge t appears on data_out after edge t+PIPELINE_DEPTH-1, i.e. it is visible for the whole cycle following that edge.
- Throughput: one bundle per cycle, unbroken.
- Reset value of data_out: 0 (depth ≥ 1), starting the cycle after the reset edge.
- Reset mid-stream: all in-flight data is discarded. After rst_i deasserts, data_out shows zeros until the first post-reset input has travelled PIPELINE_DEPTH edges.
- Reset held for several cycles: output stays 0 for the whole hold.
- Depth 0: zero latency; reset has no effect on data_out.

## Configuration
- PIPELINE_ASSERT_EN defined: simulation-only checks are elaborated.
  - Fatal error if PIPELINE_DEPTH < 0 or DATA_WIDTH < 1.
  - Warning if X/Z is present on data_in while rst_i = 0.
  - One $display of the chosen depth and width at time 0.
- PIPELINE_ASSERT_EN undefined: none of the checks exist; synthesised logic is identical in both cases.

## Structure
- No package types required. The PPU's OP_BITS and operation encoding stay in ppu_pkg; callers compute DATA_WIDTH from them, e.g. 1 + OP_BITS + 3×WORD for the front pipeline.
- One natural sub-module: pipeline_stage, a single DATA_WIDTH register with synchronous clear, instantiated PIPELINE_DEPTH times in a generate loop.
- Depth-0 bypass is a separate generate branch.

## Test plan
- Depth 0, width 8: drive 0xA5 → data_out = 0xA5 in the same cycle; toggling rst_i leaves it 0xA5.
- Depth 1, width 8: drive 0x3C before edge 1 → data_out = 0x3C after edge 1, and 0x00 before it (after reset).
- Depth 3, width 16: stream 1,2,3,4,5 on consecutive cycles → data_out shows 1..5 starting 3 edges later, one per cycle, no gaps.
- Depth 3: assert rst_i for one edge while 7,8,9 are in flight → data_out = 0 for the next 3 cycles, then post-reset inputs emerge in order.
- Depth 2, width 97 (1 + 0 + 3×32 bundle): drive all-ones, then a walking-one pattern → every bit arrives intact after 2 edges; MSB and LSB are not swapped.
- PIPELINE_ASSERT_EN defined, depth −1 → elaboration/simulation fatal; undefined → the check is absent.
